// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 stream demultiplexer.
//   N_CH          : number of output channels
//   SEL_W         : width of the destination select
//   slot_state_e  : occupancy state of a one-entry output slot
//   sel_to_onehot : binary channel index to one-hot channel mask
package demux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic logic [N_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : write i_load_data into the slot this edge
//   i_load_data    : payload to capture
//   i_ready        : downstream ready; a FULL slot drains when this is high
//   o_valid        : slot is FULL
//   o_data         : registered slot contents
//   o_can_accept   : slot can take a payload this edge (empty, or draining now)
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_can_accept
);

  slot_state_e      state_p1;
  logic [WIDTH-1:0] data_p1;

  // Load wins over drain: a same-edge drain and refill keeps the slot FULL,
  // giving one payload per cycle through the channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_p1 <= EMPTY;
      data_p1  <= '0;
    end else if (i_load) begin
      state_p1 <= FULL;
      data_p1  <= i_load_data;
    end else if (state_p1 == FULL && i_ready) begin
      state_p1 <= EMPTY;
    end
  end

  assign o_valid      = (state_p1 == FULL);
  assign o_data       = data_p1;
  assign o_can_accept = (state_p1 == EMPTY) || i_ready;

endmodule

// File: rtl/demux_1to8_stream.sv
// Registered 1-to-8 stream demultiplexer. A payload accepted on the input
// valid/ready handshake is steered by i_sel into one of eight one-entry
// slots; each slot drives its own valid/ready output channel.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_valid, o_ready : input handshake (o_ready depends on i_sel/i_ready only)
//   i_sel            : destination channel 0..7, stable while i_valid is high
//   i_data           : input payload
//   o_valid, i_ready : per-channel output handshake, bit k = channel k
//   o_data           : packed outputs, channel k at [k*WIDTH +: WIDTH]
//   o_busy           : any slot holds a payload
//   o_xfer_cnt       : accepted-transfer count, wraps at 16 bits
//                      (present only when DEMUX_1TO8_CNT_EN is defined)
module demux_1to8_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [WIDTH-1:0]      i_data,
  output logic [N_CH-1:0]       o_valid,
  input  logic [N_CH-1:0]       i_ready,
  output logic [N_CH*WIDTH-1:0] o_data,
`ifdef DEMUX_1TO8_CNT_EN
  output logic [15:0]           o_xfer_cnt,
`endif
  output logic                  o_busy
);

  logic [N_CH-1:0] sel_oh;
  logic [N_CH-1:0] can_accept;
  logic [N_CH-1:0] load;
  logic            accept;

  assign sel_oh  = sel_to_onehot(i_sel);
  assign o_ready = can_accept[i_sel];
  assign accept  = i_valid && o_ready;
  // Gating with accept keeps an unknown i_sel harmless while i_valid is low.
  assign load    = sel_oh & {N_CH{accept}};

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_load       (load[k]),
      .i_load_data  (i_data),
      .i_ready      (i_ready[k]),
      .o_valid      (o_valid[k]),
      .o_data       (o_data[k*WIDTH +: WIDTH]),
      .o_can_accept (can_accept[k])
    );
  end

  assign o_busy = |o_valid;

`ifdef DEMUX_1TO8_CNT_EN
  logic [15:0] cnt_p1;

  // Free-running modulo-2^16 count of accepted input beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_p1 <= '0;
    else if (accept) cnt_p1 <= cnt_p1 + 16'd1;
  end

  assign o_xfer_cnt = cnt_p1;
`endif

endmodule
